// File: rtl/serial_link_init_seq_if.sv
// APB bundle between the link bring-up sequencer (master) and the link configuration port (slave).
interface serial_link_init_seq_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [AddrWidth-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DataWidth-1:0] pwdata;
    logic [StrbWidth-1:0] pstrb;
    logic [2:0]           pprot;
    logic                 pready;
    logic                 pslverr;
    logic [DataWidth-1:0] prdata;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/serial_link_init_seq.sv
// Serial link bring-up sequencer: drives the link CTRL/ISOLATED registers over APB after start_i.
// Optional poll timeout enabled by defining SERIAL_LINK_INIT_SEQ_POLL_TIMEOUT_EN. rst_1_n is active-high.
module serial_link_init_seq #(
    parameter int unsigned          AddrWidth         = 32,
    parameter int unsigned          DataWidth         = 32,
    parameter logic [AddrWidth-1:0] CtrlRegOffset     = AddrWidth'(32'h0),
    parameter logic [AddrWidth-1:0] IsolatedRegOffset = AddrWidth'(32'h4),
    parameter int unsigned          WaitCycles        = 50,
    parameter int unsigned          MaxPolls          = 1024
) (
    input  logic                          clk_1,
    input  logic                          rst_1_n,
    input  logic                          start_i,
    serial_link_init_seq_if.master        apb,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [15:0]                   poll_cnt_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned WaitW     = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;

    localparam logic [DataWidth-1:0] CtrlWr0 = DataWidth'(10'h300);
    localparam logic [DataWidth-1:0] CtrlWr1 = DataWidth'(10'h302);
    localparam logic [DataWidth-1:0] CtrlWr2 = DataWidth'(10'h303);
    localparam logic [DataWidth-1:0] CtrlWr3 = DataWidth'(10'h003);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR0, ST_WR1, ST_WR2, ST_WAIT, ST_WR3, ST_POLL, ST_DONE, ST_ERROR
    } state_e;

    state_e               state_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [AddrWidth-1:0] paddr_q;
    logic [DataWidth-1:0] pwdata_q;
    logic [StrbWidth-1:0] pstrb_q;
    logic [WaitW-1:0]     wait_cnt_q;
    logic [15:0]          poll_cnt_q;
    logic [15:0]          poll_cnt_inc;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;

    assign poll_cnt_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

    // Transfer states share one SETUP/ACCESS engine; penable_q distinguishes the sub-phase.
    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            state_q    <= ST_IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            wait_cnt_q <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        state_q    <= ST_WR0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        poll_cnt_q <= '0;
                        psel_q     <= 1'b1;
                        pstrb_q    <= '1;
                        pwrite_q   <= 1'b1;
                        paddr_q    <= CtrlRegOffset;
                        pwdata_q   <= CtrlWr0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q  <= ST_WR3;
                        psel_q   <= 1'b1;
                        pstrb_q  <= '1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= CtrlRegOffset;
                        pwdata_q <= CtrlWr3;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WaitW'(1);
                    end
                end
                default: begin
                    if (!penable_q) begin
                        penable_q <= 1'b1;
                    end else if (apb.pready) begin
                        penable_q <= 1'b0;
                        if (apb.pslverr) begin
                            state_q  <= ST_ERROR;
                            error_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            psel_q   <= 1'b0;
                            pstrb_q  <= '0;
                            pwrite_q <= 1'b0;
                            paddr_q  <= '0;
                            pwdata_q <= '0;
                        end else begin
                            case (state_q)
                                ST_WR0: begin
                                    state_q  <= ST_WR1;
                                    pwdata_q <= CtrlWr1;
                                end
                                ST_WR1: begin
                                    state_q  <= ST_WR2;
                                    pwdata_q <= CtrlWr2;
                                end
                                ST_WR2: begin
                                    state_q    <= ST_WAIT;
                                    wait_cnt_q <= WaitW'(WaitCycles - 1);
                                    psel_q     <= 1'b0;
                                    pstrb_q    <= '0;
                                    pwrite_q   <= 1'b0;
                                    paddr_q    <= '0;
                                    pwdata_q   <= '0;
                                end
                                ST_WR3: begin
                                    state_q    <= ST_POLL;
                                    pwrite_q   <= 1'b0;
                                    paddr_q    <= IsolatedRegOffset;
                                    pwdata_q   <= '0;
                                    poll_cnt_q <= poll_cnt_inc;
                                end
                                ST_POLL: begin
                                    if (apb.prdata[1:0] == 2'b00) begin
                                        state_q <= ST_DONE;
                                        done_q  <= 1'b1;
                                        busy_q  <= 1'b0;
                                        psel_q  <= 1'b0;
                                        pstrb_q <= '0;
                                        paddr_q <= '0;
                                    end else begin
`ifdef SERIAL_LINK_INIT_SEQ_POLL_TIMEOUT_EN
                                        if (poll_cnt_q == 16'(MaxPolls)) begin
                                            state_q <= ST_ERROR;
                                            error_q <= 1'b1;
                                            busy_q  <= 1'b0;
                                            psel_q  <= 1'b0;
                                            pstrb_q <= '0;
                                            paddr_q <= '0;
                                        end else begin
                                            poll_cnt_q <= poll_cnt_inc;
                                        end
`else
                                        poll_cnt_q <= poll_cnt_inc;
`endif
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

`ifndef SERIAL_LINK_INIT_SEQ_POLL_TIMEOUT_EN
    logic unused_max_polls;
    assign unused_max_polls = ^32'(MaxPolls);
`endif

    // Only the two isolation bits of the status word matter.
    logic unused_prdata;
    assign unused_prdata = ^apb.prdata[DataWidth-1:2];

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;
    assign apb.pprot   = 3'b000;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign poll_cnt_o  = poll_cnt_q;
endmodule
